// File: rtl/ofc_pkg.sv
// ofc_pkg: shared types and constants for the operand forwarding controller.
//   NREG/DEPTH/AW : register count, tracked history depth, register address width
//   FWD_*         : operand mux select encodings
//   hist_t        : one history slot {valid, wr, load, rd}
//   state_t       : hazard FSM states
package ofc_pkg;

  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int AW    = $clog2(NREG);

  localparam logic [1:0] FWD_BANK = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_DM   = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic          load;
    logic [AW-1:0] rd;
  } hist_t;

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: combinational forward-select for one source operand.
//   src     in  AW      source register address
//   use_src in  1       instruction actually reads src
//   slots   in  hist_t  history, index 1 = most recently issued
//   sel     out 2       FWD_BANK / FWD_EX / FWD_DM / FWD_WB
// Nearest producing slot wins; r0 and unused sources always read the bank.
module fwd_select
  import ofc_pkg::*;
(
  input  logic [AW-1:0] src,
  input  logic          use_src,
  input  hist_t         slots [1:DEPTH],
  output logic [1:0]    sel
);

  logic [DEPTH:1] hit;
  logic [DEPTH:1] load_bits;
  logic           unused_load;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_hit
      assign hit[gi]       = slots[gi].valid && slots[gi].wr && (slots[gi].rd == src);
      assign load_bits[gi] = slots[gi].load;
    end
  endgenerate

  // Load flag only matters to the stall logic in the parent.
  assign unused_load = ^load_bits;

  always_comb begin
    sel = FWD_BANK;
    if (use_src && (src != '0)) begin
      if (hit[1])      sel = FWD_EX;
      else if (hit[2]) sel = FWD_DM;
      else if (hit[3]) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl: issue-time hazard/forwarding controller for the
// 32x16 register bank. Tracks the last three issued destinations.
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            decode presents an instruction
//   id_ra/id_rb         source registers, id_use_a/id_use_b read enables
//   id_imm              B operand is the immediate
//   id_rd/id_wr/id_load destination, write enable, load flag
//   stall               hold decode (combinational, one cycle per load-use)
//   mux_sel_a/b         registered forward selects (00 bank .. 11 ans_wb)
//   imm_sel             registered immediate select
//   rw_dm/wr_dm         bank write address/enable for the result on ans_dm
//   stall_cnt           saturating load-use stall count (HAZ_STATS_EN only)
// Optional feature macro: HAZ_STATS_EN adds the stall_cnt port and counter.
module operand_forward_ctrl
  import ofc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_ra,
  input  logic [AW-1:0] id_rb,
  input  logic          id_use_a,
  input  logic          id_use_b,
  input  logic          id_imm,
  input  logic [AW-1:0] id_rd,
  input  logic          id_wr,
  input  logic          id_load,
  output logic          stall,
  output logic [1:0]    mux_sel_a,
  output logic [1:0]    mux_sel_b,
  output logic          imm_sel,
  output logic [AW-1:0] rw_dm,
  output logic          wr_dm
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  hist_t      hist_q [1:DEPTH];
  state_t     state_q, state_d;
  logic       issue;
  logic       lu_a, lu_b, load_use;
  logic [1:0] sel_a_c, sel_b_c;

  // Load-use: the instruction one ahead is a load whose result is not ready
  // on ans_ex. The B path only counts when B is not the immediate.
  assign lu_a     = id_use_a && (id_ra != '0) && (id_ra == hist_q[1].rd);
  assign lu_b     = id_use_b && !id_imm && (id_rb != '0) && (id_rb == hist_q[1].rd);
  assign load_use = id_valid && hist_q[1].valid && hist_q[1].wr && hist_q[1].load
                    && (lu_a || lu_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // The bubble inserted by a stall moves the load to slot 2, so LU never
  // needs to stall again for the same pair.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use) begin
          stall   = 1'b1;
          state_d = LU;
        end
      end
      LU:      state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign issue = id_valid && !stall;

  // History shift register; a non-issue cycle shifts in an invalid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q[1] <= '0;
    end else if (issue) begin
      hist_q[1] <= '{valid: 1'b1, wr: id_wr, load: id_load, rd: id_rd};
    end else begin
      hist_q[1] <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q[gi] <= '0;
        else        hist_q[gi] <= hist_q[gi-1];
      end
    end
  endgenerate

  // Selects are computed from pre-shift history. B's select is computed
  // even when the immediate is chosen; the immediate mux overrides it.
  fwd_select u_sel_a (
    .src     (id_ra),
    .use_src (id_use_a),
    .slots   (hist_q),
    .sel     (sel_a_c)
  );

  fwd_select u_sel_b (
    .src     (id_rb),
    .use_src (id_use_b),
    .slots   (hist_q),
    .sel     (sel_b_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel_a <= FWD_BANK;
      mux_sel_b <= FWD_BANK;
      imm_sel   <= 1'b0;
    end else if (issue) begin
      mux_sel_a <= sel_a_c;
      mux_sel_b <= sel_b_c;
      imm_sel   <= id_imm;
    end
  end

  // Slot 2 is the instruction whose result is currently on ans_dm.
  assign wr_dm = hist_q[2].valid && hist_q[2].wr;
  assign rw_dm = wr_dm ? hist_q[2].rd : '0;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state_q == RUN) && (state_d == LU) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
